i2s_tdm_tx: RTL
===============

Name: i2s_tdm_tx

Overview:
Parametrised I2S/TDM transmit serializer. It takes one parallel frame of NUM_CH samples per valid/ready handshake and generates SCK, WS and SD from the single system clock. Unlike the fixed 32-bit shift chain it replaces, it adds configurable sample and slot widths, channel count, and I2S versus left-justified framing. It also adds a one-deep holding buffer, underrun detection and a clean enable/stop sequence. It sits between the beamformer sum path and the codec/DAC pins.

Parameters:
SAMPLE_W, 24, valid bits per sample (1..SLOT_W)
SLOT_W, 32, SCK periods per channel slot
NUM_CH, 2, channels per frame (>=2); 2 means I2S stereo, >2 means TDM
CLK_DIV, 4, clk cycles per SCK period (even, >=2)
ONE_BIT_DELAY, 1, 1 means I2S (WS leads MSB by one bit), 0 means left-justified

Ports:
clk  in  1  system clock; all logic on posedge
rst  in  1  asynchronous, active-high reset
enable  in  1  run request
s_data  in  NUM_CH*SAMPLE_W  frame; channel c occupies [c*SAMPLE_W +: SAMPLE_W]
s_valid  in  1  frame valid
s_ready  out  1  holding register empty
sck  out  1  serial bit clock
ws  out  1  word select / frame sync
sd  out  1  serial data
frame_start  out  1  1-clk pulse at each frame load
underrun  out  1  1-clk pulse when a load finds no data

Behaviour:
- Reset (async): sck=0, ws=0, sd=0, frame_start=0, underrun=0, s_ready=1. Holding register empty, counters 0, state IDLE.
- FRAME_BITS = NUM_CH*SLOT_W. div_cnt counts 0..CLK_DIV-1 in RUN/STOP.
  - div_cnt==0 is the falling event: sck<=0, and sd/ws advance to the next bit j.
  - div_cnt==CLK_DIV/2 is the rising event: sck<=1.
- All outputs are registered. sd and ws change only on falling events.
- Bit index j runs 0..FRAME_BITS-1 and wraps.
  - sd in period j is frame bit j, MSB-first within each slot.
  - Slot bits SAMPLE_W..SLOT_W-1 are zero-padded; the sample sits in the top bits.
  - k = (j+ONE_BIT_DELAY) mod FRAME_BITS.
  - NUM_CH==2: ws = (k >= SLOT_W).
  - NUM_CH>2: ws = (k == 0), a one-period pulse.
- Load event is the falling event with j==0.
  - If the holding register is full: move it to the shift register and pulse frame_start.
  - Else if s_valid is high in that cycle: bypass s_data straight into the shift register and pulse frame_start; no underrun.
  - Else: load all-zero, pulse frame_start and underrun.
- Handshake: transfer happens when s_valid && s_ready. s_ready = !hold_full, registered.
  - A hold emptied by a load raises s_ready on the next clk.
  - Data is accepted in IDLE too, so it can be preloaded.
- FSM:
  - IDLE: sck=ws=sd=0. enable=1 moves to RUN; the first falling event (j=0) occurs on the next clk.
  - RUN: enable=0 moves to STOP.
  - STOP: finishes the current frame. The falling event that would start j=0 instead returns to IDLE with sck/ws/sd=0 and no load. enable=1 during STOP moves back to RUN with no glitch.
- Reset mid-frame: outputs go to 0 immediately. Held data is discarded.

Decomposition:
- Package i2s_pkg:
  - FRAME_BITS and counter-width functions (clog2).
  - ws-mode constants (WS_STEREO, WS_TDM_PULSE).
  - FSM state encoding (IDLE, RUN, STOP).
- Sub-module i2s_sck_gen:
  - div_cnt, sck register, fall_evt/rise_evt strobes, gated by run.
  - The serializer and FSM stay in the top level.

Test Plan:
- Defaults: reset, preload ch0=0xA5A5A5 and ch1=0x5A5A5A, enable=1.
  - sd over j=0..23 = 0xA5A5A5 MSB-first, j=24..31 = 0.
  - ws low for j=0..30, high for j=31..62, low at j=63.
  - SCK period is 4 clks at 50% duty.
- ONE_BIT_DELAY=0: same stimulus. ws is high for exactly j=32..63, aligned to the ch1 MSB.
- NUM_CH=4, SLOT_W=16, SAMPLE_W=16, data 0x8001/0x0002/0x0004/0xFFFF:
  - ws is high only at j=63, one period before frame start.
  - Each slot's bits appear in order.
- Underrun: after one frame, hold s_valid low.
  - Next load gives a 1-clk underrun and frame_start, then 64 zero bits.
  - Assert s_valid in the exact load cycle: bypass, no underrun.
- Back-pressure: hold s_valid high continuously.
  - s_ready drops after accept and rises 1 clk after each load.
  - Frames are transmitted in order with none lost or duplicated.
- Stop/reset: deassert enable at j=10. The frame completes through j=63, then sck/ws/sd=0 with no extra load. Assert rst mid-frame: all outputs 0 in the same cycle and s_ready=1.

Source files
------------

// File: rtl/i2s_pkg.sv
// Shared constants and sizing helpers for the I2S/TDM transmit path.
package i2s_pkg;

  localparam logic WS_STEREO    = 1'b0;
  localparam logic WS_TDM_PULSE = 1'b1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_STOP = 2'd2;

  function automatic int frame_bits(input int num_ch, input int slot_w);
    return num_ch * slot_w;
  endfunction

  // Width of a counter that runs 0..n-1.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic logic ws_mode(input int num_ch);
    return (num_ch == 2) ? WS_STEREO : WS_TDM_PULSE;
  endfunction

endpackage

// File: rtl/i2s_sck_gen.sv
// Bit-clock divider: registered SCK plus a falling-event strobe.
module i2s_sck_gen
  import i2s_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_run,
  output logic o_sck,
  output logic o_fall
);

  localparam int DW = cnt_w(CLK_DIV);
  localparam logic [DW-1:0] LAST = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] HALF = DW'(CLK_DIV / 2);

  logic [DW-1:0] r_div;
  logic          r_sck;
  logic          w_rise;

  assign o_fall = i_run && (r_div == '0);
  assign w_rise = i_run && (r_div == HALF);
  assign o_sck  = r_sck;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div <= '0;
      r_sck <= 1'b0;
    end else if (!i_run) begin
      r_div <= '0;
      r_sck <= 1'b0;
    end else begin
      r_div <= (r_div == LAST) ? '0 : r_div + 1'b1;
      if (o_fall)
        r_sck <= 1'b0;
      else if (w_rise)
        r_sck <= 1'b1;
    end
  end

endmodule

// File: rtl/i2s_tdm_tx.sv
// I2S / TDM transmit serializer with a one-deep holding buffer,
// underrun detection and an orderly stop at the frame boundary.
module i2s_tdm_tx
  import i2s_pkg::*;
#(
  parameter int SAMPLE_W      = 24,
  parameter int SLOT_W        = 32,
  parameter int NUM_CH        = 2,
  parameter int CLK_DIV       = 4,
  parameter int ONE_BIT_DELAY = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enable,
  input  logic [NUM_CH*SAMPLE_W-1:0] s_data,
  input  logic                       s_valid,
  output logic                       s_ready,
  output logic                       sck,
  output logic                       ws,
  output logic                       sd,
  output logic                       frame_start,
  output logic                       underrun
);

  localparam int FB = frame_bits(NUM_CH, SLOT_W);
  localparam int BW = cnt_w(FB);
  localparam int DW = NUM_CH * SAMPLE_W;
  localparam logic MODE = ws_mode(NUM_CH);
  localparam logic [BW-1:0] LAST_BIT = BW'(FB - 1);
  localparam logic [BW-1:0] SLOT_B   = BW'(SLOT_W);

  logic [1:0]    r_state;
  logic [BW-1:0] r_bit;
  logic [FB-1:0] r_shift;
  logic [DW-1:0] r_hold;
  logic          r_hold_full;
  logic          r_ready;
  logic          r_ws;
  logic          r_sd;
  logic          r_fs;
  logic          r_ur;

  logic          w_run;
  logic          w_fall;
  logic          w_sck;
  logic          w_start;
  logic          w_keep;
  logic          w_load;
  logic          w_halt;
  logic          w_accept;
  logic          w_full_nxt;
  logic [BW-1:0] w_k;
  logic          w_ws_nxt;
  logic [DW-1:0] w_src;
  logic [FB-1:0] w_frame;

  // Slot c goes out c-th, sample MSB-aligned, low pad bits zero.
  function automatic logic [FB-1:0] fmt(input logic [DW-1:0] d);
    logic [FB-1:0] f;
    f = '0;
    for (int c = 0; c < NUM_CH; c++)
      f[FB-1-c*SLOT_W -: SLOT_W] =
        SLOT_W'(d[c*SAMPLE_W +: SAMPLE_W]) << (SLOT_W - SAMPLE_W);
    return f;
  endfunction

  i2s_sck_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_sck (
    .clk   (clk),
    .rst   (rst),
    .i_run (w_run),
    .o_sck (w_sck),
    .o_fall(w_fall)
  );

  assign w_run    = (r_state != ST_IDLE);
  assign w_start  = w_fall && (r_bit == '0);
  assign w_keep   = (r_state == ST_RUN) ||
                    ((r_state == ST_STOP) && enable);
  assign w_load   = w_start && w_keep;
  assign w_halt   = w_start && (r_state == ST_STOP) && !enable;
  assign w_accept = s_valid && r_ready;

  always_comb begin
    w_k = r_bit;
    if (ONE_BIT_DELAY != 0)
      w_k = (r_bit == LAST_BIT) ? '0 : r_bit + 1'b1;
  end

  assign w_ws_nxt = (MODE == WS_STEREO) ? (w_k >= SLOT_B)
                                        : (w_k == '0);
  assign w_src    = r_hold_full ? r_hold : (s_valid ? s_data : '0);
  assign w_frame  = fmt(w_src);

  // A load that bypasses s_data leaves the holding register empty.
  always_comb begin
    w_full_nxt = r_hold_full;
    if (w_load)
      w_full_nxt = 1'b0;
    else if (w_accept)
      w_full_nxt = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: if (enable) r_state <= ST_RUN;
        ST_RUN:  if (!enable) r_state <= ST_STOP;
        ST_STOP: begin
          if (w_halt)
            r_state <= ST_IDLE;
          else if (enable)
            r_state <= ST_RUN;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bit   <= '0;
      r_shift <= '0;
      r_ws    <= 1'b0;
      r_sd    <= 1'b0;
    end else if (w_halt) begin
      r_bit <= '0;
      r_ws  <= 1'b0;
      r_sd  <= 1'b0;
    end else if (w_fall) begin
      r_bit <= (r_bit == LAST_BIT) ? '0 : r_bit + 1'b1;
      r_ws  <= w_ws_nxt;
      if (w_load) begin
        r_sd    <= w_frame[FB-1];
        r_shift <= w_frame << 1;
      end else begin
        r_sd    <= r_shift[FB-1];
        r_shift <= r_shift << 1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hold      <= '0;
      r_hold_full <= 1'b0;
      r_ready     <= 1'b1;
      r_fs        <= 1'b0;
      r_ur        <= 1'b0;
    end else begin
      r_hold_full <= w_full_nxt;
      r_ready     <= !w_full_nxt;
      r_fs        <= w_load;
      r_ur        <= w_load && !r_hold_full && !s_valid;
      if (w_accept && !w_load)
        r_hold <= s_data;
    end
  end

  assign s_ready     = r_ready;
  assign sck         = w_sck;
  assign ws          = r_ws;
  assign sd          = r_sd;
  assign frame_start = r_fs;
  assign underrun    = r_ur;

endmodule
